spawn_scheduler: RTL and testbench
==================================

Name: spawn_scheduler

Overview:
- Central scheduler that decides when each scrolling sprite layer (clouds, cacti, birds) may emit a new sprite, replacing per-layer ad-hoc random emission.
- Holds a shared LFSR, a pixel-distance gap counter and a round-robin arbiter. Issues one-cycle spawn grants with a random vertical offset.
- Sits between the game-state logic (start/crash) and the sprite layer modules. It advances on the same scroll tick those layers use to move.

Parameters:
- NREQ, 3, number of requesting sprite layers.
- MIN_GAP, 200, minimum scroll pixels between consecutive grants.
- GAP_MASK, 8'hFF, mask applied to LFSR[7:0] to form the random extra gap (extra = lfsr[7:0] & GAP_MASK).
- SEED, 16'hACE1, LFSR reset/restart value; must be nonzero.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin or restart a game.
- crash  in  1  one-cycle pulse: game over.
- scroll_tick  in  1  one-cycle pulse per one-pixel scroll step.
- req  in  NREQ  per-layer spawn request; level, held until granted or withdrawn.
- grant  out  NREQ  one-hot, one-cycle spawn grant.
- y_off  out  6  random vertical offset (0..45), valid in the grant cycle, held until the next grant.
- state  out  2  00 IDLE, 01 RUN, 10 HALT.
- spawn_cnt  out  16  number of grants since the last start.
- rand_out  out  16  current LFSR value, for other consumers.

Behaviour:
- Reset (rstn low, async): state=IDLE, grant=0, y_off=0, spawn_cnt=0, lfsr=SEED, gap=MIN_GAP, rr pointer=0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every clk in every state and is never zero.
- FSM transitions:
  - IDLE: start -> RUN.
  - RUN: crash -> HALT. start is ignored.
  - HALT: start -> RUN. crash is ignored.
- Entering RUN (from IDLE or HALT): gap=MIN_GAP, spawn_cnt=0, rr pointer=0, lfsr=SEED. The restart sequence is deterministic.
- Gap counter: 10-bit, saturating at 0.
  - Decrements by 1 on scroll_tick in RUN only.
  - Frozen in IDLE and HALT.
- Grant condition, evaluated each cycle: state==RUN, gap==0, |req, crash==0.
  - Arbiter selects the first asserted req at or after the rr pointer, scanning upward and wrapping.
  - grant is registered and asserts exactly one cycle after the condition is sampled true.
  - Next cycle: rr pointer = granted index + 1, modulo NREQ.
- On grant:
  - gap reloads to MIN_GAP + (lfsr[7:0] & GAP_MASK), computed in 10 bits without overflow for the defaults.
  - spawn_cnt increments, wrapping at 16'hFFFF -> 0.
  - y_off latches r, where r = lfsr[5:0]: y_off = r if r < 46, else r - 46.
- Back-to-back: after a grant, gap≥MIN_GAP>0, so at least MIN_GAP scroll_ticks separate consecutive grants. grant is never high two cycles in a row.
- Simultaneous events:
  - scroll_tick in the grant-decision cycle: the reload wins and the decrement is discarded.
  - crash in the grant-decision cycle: no grant, transition to HALT.
  - start and crash together in RUN: crash wins.
  - start and crash together in HALT: start wins.
- Request withdrawn before the grant cycle: condition re-evaluated next cycle; no stale grant is issued.
- grant is forced to 0 in IDLE and HALT, including the cycle after a crash.
- Reset mid-operation: immediate return to reset values; any pending grant is dropped.

Test Plan:
- Reset release, start pulse, req=3'b001 held, scroll_tick every 4 clks -> first grant=3'b001 one clk after the 200th tick is processed; spawn_cnt=1; gap reloads to 200+(lfsr[7:0]).
- req=3'b111 held through 4 grants -> grant sequence 001,010,100,001; successive grants separated by ≥200 ticks.
- Force r=6'd50 at grant (known LFSR state after SEED) -> y_off=4. Check y_off is always ≤45 over 1000 grants.
- crash in the exact cycle gap==0 with req=001 -> no grant, state=HALT. Further scroll_ticks leave gap at 0; grant stays 0.
- start in HALT -> state=RUN, spawn_cnt=0, rand_out=16'hACE1 next cycle, gap=200. Replaying the stimulus reproduces the identical grant/y_off sequence.
- rstn asserted mid-RUN while req is high and gap==0 -> grant=0 and state=IDLE immediately (asynchronous). No grant after release until start.

Source files
------------

// File: rtl/spawn_scheduler.sv
// spawn_scheduler: paces sprite spawns across the scrolling layers using a
// shared LFSR, a scroll-distance gap counter and a round-robin arbiter.
module spawn_scheduler #(
   parameter int unsigned NREQ     = 3,
   parameter int unsigned MIN_GAP  = 200,
   parameter logic [7:0]  GAP_MASK = 8'hFF,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic            crash,
   input  logic            scroll_tick,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic [5:0]      y_off,
   output logic [1:0]      state,
   output logic [15:0]     spawn_cnt,
   output logic [15:0]     rand_out
);

   localparam int unsigned PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned SW     = PW + 1;
   localparam int unsigned GW     = 10;
   localparam logic [15:0] TAPS   = 16'hB400;
   localparam logic [5:0]  Y_SPAN = 6'd46;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HALT = 2'b10
   } state_t;

   state_t        state_q;
   logic [15:0]   lfsr_q;
   logic [GW-1:0] gap_q;
   logic [PW-1:0] rr_q;

   logic [15:0]   lfsr_nxt;
   logic [PW-1:0] sel_idx;
   logic          sel_vld;
   logic [SW-1:0] scan_sum;
   logic [GW-1:0] gap_reload;
   logic [5:0]    y_fold;
   logic [PW-1:0] rr_nxt;
   logic          restart;
   logic          grant_ok;

   // Galois step for x^16+x^14+x^13+x^11+1; never reaches zero from a nonzero seed
   always_comb lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

   // Round-robin pick: first request at or after the pointer, wrapping
   always_comb begin
      sel_idx  = '0;
      sel_vld  = 1'b0;
      scan_sum = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_sum = {1'b0, rr_q} + SW'(k);
         if (scan_sum >= SW'(NREQ)) scan_sum = scan_sum - SW'(NREQ);
         if (!sel_vld && req[scan_sum[PW-1:0]]) begin
            sel_vld = 1'b1;
            sel_idx = scan_sum[PW-1:0];
         end
      end
   end

   // Grant-side arithmetic: next gap, folded vertical offset, next pointer
   always_comb begin
      gap_reload = GW'(MIN_GAP) + GW'(lfsr_q[7:0] & GAP_MASK);
      y_fold     = (lfsr_q[5:0] < Y_SPAN) ? lfsr_q[5:0] : lfsr_q[5:0] - Y_SPAN;
      rr_nxt     = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + PW'(1);
      restart    = start && ((state_q == IDLE) || (state_q == HALT));
      grant_ok   = (state_q == RUN) && (gap_q == '0) && sel_vld && !crash;
   end

   // Game-state FSM, gap counter, arbiter pointer and registered grant outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         lfsr_q    <= SEED;
         gap_q     <= GW'(MIN_GAP);
         rr_q      <= '0;
         grant     <= '0;
         y_off     <= '0;
         spawn_cnt <= '0;
      end else begin
         lfsr_q <= lfsr_nxt;
         grant  <= '0;
         if (restart) begin
            state_q   <= RUN;
            lfsr_q    <= SEED;
            gap_q     <= GW'(MIN_GAP);
            rr_q      <= '0;
            spawn_cnt <= '0;
         end else if (state_q == RUN) begin
            if (crash) begin
               state_q <= HALT;
            end else if (grant_ok) begin
               grant     <= NREQ'(1) << sel_idx;
               gap_q     <= gap_reload;
               spawn_cnt <= spawn_cnt + 16'd1;
               y_off     <= y_fold;
               rr_q      <= rr_nxt;
            end else if (scroll_tick && (gap_q != '0)) begin
               gap_q <= gap_q - GW'(1);
            end
         end
      end
   end

   assign state    = state_q;
   assign rand_out = lfsr_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: directed scoreboard bench for spawn_scheduler.
module tb_spawn_scheduler;

   localparam int unsigned NREQ    = 3;
   localparam int unsigned MIN_GAP = 200;
   localparam logic [15:0] SEED    = 16'hACE1;

   typedef struct packed {
      logic [NREQ-1:0] g;
      logic [5:0]      y;
      logic [15:0]     c;
   } exp_t;

   logic            clk = 1'b0;
   logic            rstn;
   logic            start;
   logic            crash;
   logic            scroll_tick;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] grant;
   logic [5:0]      y_off;
   logic [1:0]      state;
   logic [15:0]     spawn_cnt;
   logic [15:0]     rand_out;

   int n_cmp = 0;
   int n_mis = 0;

   // reference model state
   logic [1:0]      m_state;
   logic [15:0]     m_lfsr;
   int              m_gap;
   int              m_rr;
   logic [15:0]     m_cnt;
   logic [5:0]      m_yoff;
   logic [NREQ-1:0] m_gnt;
   exp_t            sbq[$];
   exp_t            last_e;
   exp_t            rec[$];
   int              ticks_since;
   bit              have_prev;

   spawn_scheduler #(
      .NREQ    (NREQ),
      .MIN_GAP (MIN_GAP),
      .GAP_MASK(8'hFF),
      .SEED    (SEED)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .crash      (crash),
      .scroll_tick(scroll_tick),
      .req        (req),
      .grant      (grant),
      .y_off      (y_off),
      .state      (state),
      .spawn_cnt  (spawn_cnt),
      .rand_out   (rand_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   task automatic model_reset();
      m_state     = 2'b00;
      m_lfsr      = SEED;
      m_gap       = MIN_GAP;
      m_rr        = 0;
      m_cnt       = '0;
      m_yoff      = '0;
      m_gnt       = '0;
      have_prev   = 1'b0;
      ticks_since = 0;
      sbq.delete();
   endtask

   task automatic model_clock(input logic s, input logic c, input logic t, input logic [NREQ-1:0] r);
      logic [15:0] nxt;
      bit          enter;
      int          idx;
      exp_t        e;
      nxt   = lfsr_step(m_lfsr);
      enter = 1'b0;
      m_gnt = '0;
      if (m_state == 2'b01) begin
         if (c) begin
            m_state = 2'b10;
         end else if (m_gap == 0 && r != '0) begin
            idx = -1;
            for (int k = 0; k < NREQ; k++)
               if (idx < 0 && r[(m_rr + k) % NREQ]) idx = (m_rr + k) % NREQ;
            m_gnt  = NREQ'(1 << idx);
            m_gap  = MIN_GAP + int'(m_lfsr[7:0]);
            m_cnt  = m_cnt + 16'd1;
            m_yoff = (m_lfsr[5:0] < 6'd46) ? m_lfsr[5:0] : m_lfsr[5:0] - 6'd46;
            m_rr   = (idx + 1) % NREQ;
            e.g = m_gnt; e.y = m_yoff; e.c = m_cnt;
            sbq.push_back(e);
         end else if (t && m_gap > 0) begin
            m_gap = m_gap - 1;
         end
      end else if (s) begin
         enter = 1'b1;
      end
      m_lfsr = nxt;
      if (enter) begin
         m_state = 2'b01;
         m_gap   = MIN_GAP;
         m_cnt   = '0;
         m_rr    = 0;
         m_lfsr  = SEED;
      end
   endtask

   task automatic check_cycle();
      if (m_gnt != '0) begin
         chk("sb_depth", sbq.size(), 1);
         if (sbq.size() > 0) begin
            last_e = sbq.pop_front();
            chk("grant", grant, last_e.g);
            chk("y_off_at_grant", y_off, last_e.y);
            chk("cnt_at_grant", spawn_cnt, last_e.c);
            chk("y_off_range", (y_off <= 6'd45), 1);
         end
      end else begin
         chk("grant_quiet", grant, '0);
      end
      if (grant != '0) begin
         if (have_prev) chk("gap_ticks_min", (ticks_since >= MIN_GAP), 1);
         have_prev   = 1'b1;
         ticks_since = 0;
      end
      chk("state", state, m_state);
      chk("rand_out", rand_out, m_lfsr);
      chk("spawn_cnt", spawn_cnt, m_cnt);
      chk("y_off", y_off, m_yoff);
   endtask

   task automatic step(input logic s, input logic c, input logic t, input logic [NREQ-1:0] r);
      start = s; crash = c; scroll_tick = t; req = r;
      @(posedge clk);
      model_clock(s, c, t, r);
      if (t) ticks_since++;
      if (s) have_prev = 1'b0;
      @(negedge clk);
      check_cycle();
   endtask

   task automatic wait_grant(input logic [NREQ-1:0] r, input int unsigned div, input int unsigned budget);
      int unsigned n;
      n = 0;
      do begin
         step(1'b0, 1'b0, (n % div) == 0, r);
         n++;
      end while (grant == '0 && n < budget);
      chk("grant_timeout", (grant != '0), 1);
   endtask

   task automatic drain_gap(input int unsigned budget);
      int unsigned n;
      n = 0;
      while (m_gap != 0 && n < budget) begin
         step(1'b0, 1'b0, 1'b1, '0);
         n++;
      end
   endtask

   initial begin
      logic [NREQ-1:0] exp_seq[4];
      logic [NREQ-1:0] rq;
      int unsigned     n;

      rstn = 1'b0; start = 1'b0; crash = 1'b0; scroll_tick = 1'b0; req = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_state", state, 2'b00);
      chk("rst_grant", grant, '0);
      chk("rst_y_off", y_off, '0);
      chk("rst_cnt", spawn_cnt, '0);
      chk("rst_lfsr", rand_out, 16'hACE1);
      rstn = 1'b1;
      repeat (5) step(1'b0, 1'b0, 1'b0, '0);

      // first grant lands one clock after the 200th processed tick
      step(1'b1, 1'b0, 1'b0, 3'b001);
      chk("start_state", state, 2'b01);
      chk("start_seed", rand_out, 16'hACE1);
      repeat (199) begin
         step(1'b0, 1'b0, 1'b1, 3'b001);
         repeat (3) step(1'b0, 1'b0, 1'b0, 3'b001);
      end
      step(1'b0, 1'b0, 1'b1, 3'b001);
      chk("pre_first_grant", grant, '0);
      step(1'b0, 1'b0, 1'b0, 3'b001);
      chk("first_grant", grant, 3'b001);
      chk("first_cnt", spawn_cnt, 16'd1);

      // all layers requesting: rotation continues from pointer 1
      exp_seq[0] = 3'b010; exp_seq[1] = 3'b100; exp_seq[2] = 3'b001;
      for (int i = 0; i < 3; i++) begin
         wait_grant(3'b111, 1, 2000);
         chk("rr_rotate", grant, exp_seq[i]);
      end

      // steer the decision onto an LFSR state with r == 50 -> y_off == 4
      drain_gap(600);
      n = 0;
      while (m_lfsr[5:0] != 6'd50 && n < 5000) begin
         step(1'b0, 1'b0, 1'b0, '0);
         n++;
      end
      step(1'b0, 1'b0, 1'b0, 3'b001);
      chk("y_off_r50", y_off, 6'd4);

      // bulk grants with random request mixes; range checked at every grant
      for (int i = 0; i < 60; i++) begin
         rq = NREQ'($urandom_range(1, 7));
         wait_grant(rq, 1, 600);
      end

      // crash in the decision cycle suppresses the grant
      drain_gap(600);
      step(1'b0, 1'b1, 1'b0, 3'b001);
      chk("crash_state", state, 2'b10);
      chk("crash_grant", grant, '0);
      repeat (20) step(1'b0, 1'b0, 1'b1, 3'b001);
      chk("halt_grant", grant, '0);

      // restart from HALT and record the deterministic sequence
      step(1'b1, 1'b0, 1'b0, '0);
      chk("restart_state", state, 2'b01);
      chk("restart_cnt", spawn_cnt, '0);
      chk("restart_seed", rand_out, 16'hACE1);
      exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
      rec.delete();
      for (int i = 0; i < 4; i++) begin
         wait_grant(3'b111, 2, 2000);
         chk("fresh_rr", grant, exp_seq[i]);
         rec.push_back(last_e);
      end

      // start+crash: crash wins in RUN, start wins in HALT
      step(1'b1, 1'b1, 1'b0, '0);
      chk("run_sc_state", state, 2'b10);
      step(1'b1, 1'b1, 1'b0, '0);
      chk("halt_sc_state", state, 2'b01);
      chk("halt_sc_seed", rand_out, 16'hACE1);
      for (int i = 0; i < 4; i++) begin
         wait_grant(3'b111, 2, 2000);
         if (i < rec.size()) begin
            chk("replay_grant", grant, rec[i].g);
            chk("replay_y_off", y_off, rec[i].y);
         end
      end

      // asynchronous reset with a grant pending
      drain_gap(600);
      req = 3'b001; start = 1'b0; crash = 1'b0; scroll_tick = 1'b0;
      #2 rstn = 1'b0;
      #1;
      chk("async_rst_grant", grant, '0);
      chk("async_rst_state", state, 2'b00);
      chk("async_rst_cnt", spawn_cnt, '0);
      chk("async_rst_lfsr", rand_out, 16'hACE1);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (30) step(1'b0, 1'b0, 1'b1, 3'b001);
      chk("post_rst_idle", state, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
